// File: rtl/lcd_string_ctrl.sv
// lcd_string_ctrl: HD44780-style character LCD writer.
// Powers up the panel, then writes one character per accepted button press,
// wrapping the cursor across COLS x ROWS and servicing clear requests.
// Build option: define LCD_NIBBLE_MODE_EN for a 4-bit bus (two nibble transfers
// per byte on data[7:4]); the default build drives the full 8-bit bus.
module lcd_string_ctrl #(
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int E_PULSE_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 80000,
  parameter int PWR_WAIT_CYC = 750000,
  parameter int DEB_CYC      = 500000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [7:0]                             data_btn,
  input  logic                                   button,
  input  logic                                   debounce_en,
  input  logic                                   clear_req,
  output logic                                   busy,
  output logic [(COLS>1 ? $clog2(COLS) : 1)-1:0] cursor_col,
  output logic                                   cursor_row,
  output logic                                   RW,
  output logic                                   RS,
  output logic                                   E,
  output logic [7:0]                             data
);

  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MAX_A = (PWR_WAIT_CYC > CLR_WAIT_CYC) ? PWR_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_B = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] E_LAST   = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [DEB_W-1:0] DEB_SAT  = DEB_W'(DEB_CYC);
  localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);

`ifdef LCD_NIBBLE_MODE_EN
  localparam bit       NIBBLE = 1'b1;
  localparam int       INIT_N = 5;
`else
  localparam bit       NIBBLE = 1'b0;
  localparam int       INIT_N = 4;
`endif
  localparam logic [2:0] INIT_LAST = 3'(INIT_N - 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, WRITE, ADDR, CLEAR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       init_idx, init_idx_n;
  logic             nib_lo, nib_lo_n;
  logic [7:0]       chr, chr_n;
  logic [CW-1:0]    col, col_n;
  logic             row, row_n;
  logic             clr_pend, clr_pend_n;

  logic [DEB_W-1:0] deb_cnt;
  logic             button_d;
  logic             press;

  logic [7:0]       init_byte, cur_byte, bus_byte;
  logic [CNT_W-1:0] wait_last;
  logic             single;
  logic             xfer_state;

  // Button history: previous level for edge mode, saturating high-time counter for debounce
  always_ff @(posedge clk) begin
    if (reset) begin
      button_d <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      button_d <= button;
      if (!button)             deb_cnt <= '0;
      else if (deb_cnt != DEB_SAT) deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // One acceptance per high period: counter saturates past DEB_LAST, edge needs a low first
  always_comb begin
    press = debounce_en ? (button && (deb_cnt == DEB_LAST)) : (button && !button_d);
  end

  // Byte being transferred in the current state, and what actually goes on the bus
  always_comb begin
    init_byte = 8'h00;
    case (init_idx)
`ifdef LCD_NIBBLE_MODE_EN
      3'd0: init_byte = 8'h20;
      3'd1: init_byte = 8'h28;
      3'd2: init_byte = 8'h0C;
      3'd3: init_byte = 8'h01;
      3'd4: init_byte = 8'h06;
`else
      3'd0: init_byte = 8'h38;
      3'd1: init_byte = 8'h0C;
      3'd2: init_byte = 8'h01;
      3'd3: init_byte = 8'h06;
`endif
      default: init_byte = 8'h00;
    endcase
    cur_byte = 8'h00;
    case (state)
      INIT:    cur_byte = init_byte;
      WRITE:   cur_byte = chr;
      ADDR:    cur_byte = {1'b1, row, 6'b0};
      CLEAR:   cur_byte = 8'h01;
      default: cur_byte = 8'h00;
    endcase
    bus_byte   = NIBBLE ? {(nib_lo ? cur_byte[3:0] : cur_byte[7:4]), 4'h0} : cur_byte;
    wait_last  = (cur_byte == 8'h01) ? CLR_LAST : CMD_LAST;
    // the very first nibble-mode init word is a lone high nibble
    single     = NIBBLE && (state == INIT) && (init_idx == 3'd0);
    xfer_state = (state == INIT) || (state == WRITE) || (state == ADDR) || (state == CLEAR);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PWR_WAIT;
      phase    <= PH_SETUP;
      cnt      <= '0;
      init_idx <= '0;
      nib_lo   <= 1'b0;
      chr      <= 8'h00;
      col      <= '0;
      row      <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
      init_idx <= init_idx_n;
      nib_lo   <= nib_lo_n;
      chr      <= chr_n;
      col      <= col_n;
      row      <= row_n;
      clr_pend <= clr_pend_n;
    end
  end

  // Next state: power-up wait, idle dispatch, and the shared setup/pulse/hold/wait transfer
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    cnt_n      = cnt;
    init_idx_n = init_idx;
    nib_lo_n   = nib_lo;
    chr_n      = chr;
    col_n      = col;
    row_n      = row;
    clr_pend_n = clr_pend;
    // clear during power-up/init is dropped since init clears anyway
    if (clear_req && ((state == WRITE) || (state == ADDR) || (state == CLEAR)))
      clr_pend_n = 1'b1;
    case (state)
      PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          state_n    = INIT;
          phase_n    = PH_SETUP;
          cnt_n      = '0;
          init_idx_n = '0;
          nib_lo_n   = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        phase_n  = PH_SETUP;
        cnt_n    = '0;
        nib_lo_n = 1'b0;
        // clear outranks a press in the same cycle; that press is lost
        if (clr_pend || clear_req) begin
          state_n    = CLEAR;
          clr_pend_n = 1'b0;
        end else if (press) begin
          state_n = WRITE;
          chr_n   = data_btn;
        end
      end
      default: begin
        case (phase)
          PH_SETUP: begin
            phase_n = PH_PULSE;
            cnt_n   = '0;
          end
          PH_PULSE: begin
            if (cnt == E_LAST) begin
              phase_n = PH_HOLD;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          PH_HOLD: begin
            cnt_n = '0;
            // high nibble goes straight into the low nibble, no settle wait
            if (NIBBLE && !nib_lo && !single) begin
              phase_n  = PH_SETUP;
              nib_lo_n = 1'b1;
            end else begin
              phase_n = PH_WAIT;
            end
          end
          default: begin
            if (cnt == wait_last) begin
              cnt_n    = '0;
              phase_n  = PH_SETUP;
              nib_lo_n = 1'b0;
              case (state)
                INIT: begin
                  if (init_idx == INIT_LAST) begin
                    state_n = IDLE;
                    col_n   = '0;
                    row_n   = 1'b0;
                  end else begin
                    init_idx_n = init_idx + 1'b1;
                  end
                end
                WRITE: begin
                  if (col == COL_LAST) begin
                    col_n   = '0;
                    row_n   = (ROWS == 2) ? ~row : 1'b0;
                    state_n = ADDR;
                  end else begin
                    col_n   = col + 1'b1;
                    state_n = IDLE;
                  end
                end
                ADDR:  state_n = IDLE;
                CLEAR: begin
                  state_n = IDLE;
                  col_n   = '0;
                  row_n   = 1'b0;
                end
                default: state_n = IDLE;
              endcase
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  // Outputs: bus is driven for the whole transfer, E only in the pulse phase
  always_comb begin
    busy       = (state != IDLE);
    RW         = 1'b0;
    RS         = 1'b0;
    E          = 1'b0;
    data       = 8'h00;
    cursor_col = col;
    cursor_row = row;
    if (xfer_state) begin
      E    = (phase == PH_PULSE);
      RS   = (state == WRITE);
      data = bus_byte;
    end
  end

endmodule

// File: doc/lcd_string_ctrl.md
LCD_STRING_CTRL -- requirements
Module: lcd_string_ctrl

Interface
REQ-001 Parameter COLS, default 16: characters per display row, 1..40.
REQ-002 Parameter ROWS, default 2: display rows, 1 or 2.
REQ-003 Parameter E_PULSE_CYC, default 25: clk cycles E is held high per transfer, >=1.
REQ-004 Parameter CMD_WAIT_CYC, default 2000: idle cycles after any transfer except clear, >=1.
REQ-005 Parameter CLR_WAIT_CYC, default 80000: idle cycles after a 0x01 clear command, >=1.
REQ-006 Parameter PWR_WAIT_CYC, default 750000: power-up wait before the first init command, >=1.
REQ-007 Parameter DEB_CYC, default 500000: stable-high cycles required to accept button when debounce_en=1, >=1.
REQ-008 clk  input  1  the one clock; all logic is rising-edge clk.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 data_btn  input  8  character code written on an accepted press.
REQ-011 button  input  1  write request, level, asynchronous to nothing (already in clk domain).
REQ-012 debounce_en  input  1  1 = apply DEB_CYC filter to button; 0 = accept raw rising edge.
REQ-013 clear_req  input  1  single-cycle pulse: clear display and home cursor.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 cursor_col  output  $clog2(COLS)  column of the next character.
REQ-016 cursor_row  output  1  row of the next character (always 0 when ROWS=1).
REQ-017 RW  output  1  LCD read/write; tied 0 (write only).
REQ-018 RS  output  1  LCD register select: 0 command, 1 data.
REQ-019 E  output  1  LCD enable strobe.
REQ-020 data  output  8  LCD data bus.

Function
REQ-021 States: PWR_WAIT, INIT, IDLE, WRITE, ADDR, CLEAR; each byte transfer is: 1 setup cycle (RS/data valid, E=0), E=1 for E_PULSE_CYC cycles, E=0 for 1 hold cycle, then wait CMD_WAIT_CYC (CLR_WAIT_CYC if byte is 0x01).
REQ-022 RS and data are held stable from setup cycle through hold cycle of each transfer.
REQ-023 PWR_WAIT counts PWR_WAIT_CYC cycles then enters INIT.
REQ-024 INIT sends commands in order 0x38 (0x28 with macro), 0x0C, 0x01, 0x06, then enters IDLE with cursor 0,0.
REQ-025 Press acceptance: debounce_en=0 -> button rising edge (0 in previous cycle, 1 now); debounce_en=1 -> button high for DEB_CYC consecutive cycles; at most one acceptance per high period.
REQ-026 Accepted press in IDLE -> WRITE sends data_btn (sampled at acceptance) with RS=1.
REQ-027 After WRITE, cursor_col increments; if it was COLS-1, cursor_col=0, cursor_row toggles (stays 0 if ROWS=1) and ADDR sends 0x80|(row?0x40:0x00) with RS=0 before IDLE.
REQ-028 Presses accepted while busy are discarded; a debounced press still pending when busy falls is accepted normally.
REQ-029 clear_req in IDLE -> CLEAR sends 0x01, cursor 0,0 on completion; clear_req while busy is latched (one deep) and serviced on the next IDLE cycle.
REQ-030 Pending clear and accepted press in the same IDLE cycle: clear wins, press discarded.
REQ-031 clear_req during PWR_WAIT/INIT is ignored (INIT already clears).

Reset
REQ-032 reset high: state PWR_WAIT, all counters 0, pending clear 0, cursor 0,0, E=0, RS=0, RW=0, data=0x00, busy=1.
REQ-033 reset asserted mid-transfer drops E to 0 on the next clk edge and restarts the full power-up sequence.

Configuration
REQ-034 Macro LCD_NIBBLE_MODE_EN defined: 4-bit bus; each byte sent as two full transfers (high nibble then low nibble) on data[7:4], data[3:0]=0, wait only after low nibble; INIT first sends single nibble 0x2 then the command list.
REQ-035 Macro absent: 8-bit bus, one transfer per byte as REQ-021.

Verification (COLS=4, ROWS=2, E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, PWR_WAIT_CYC=10, DEB_CYC=3)
REQ-036 Release reset -> E first rises after 10+1 cycles with data=0x38, RS=0; then 0x0C, 0x01, 0x06; busy falls, cursor 0,0.
REQ-037 debounce_en=0, data_btn=0x83, button rises -> one transfer RS=1 data=0x83, E high 2 cycles, cursor_col=1.
REQ-038 debounce_en=1, button high 2 cycles then low -> no transfer; high 3 cycles -> one transfer; held high 50 cycles -> still one.
REQ-039 Four writes from 0,0 -> after fourth, command 0x C0 (0x80|0x40) RS=0, cursor 0,1; four more -> 0x80, cursor 0,0.
REQ-040 clear_req pulsed during a char write -> after write completes, 0x01 sent, 8-cycle wait, cursor 0,0; simultaneous button press discarded.
REQ-041 reset pulsed while E=1 -> E=0 next cycle, busy=1, power-up sequence repeats from REQ-036.
